// File: rtl/tm1638_sched_pkg.sv
// tm1638_sched_pkg: scheduler state encoding, default timing and counter width helpers
package tm1638_sched_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    // clog2 that never returns 0, so a 1-entry range still gets a 1-bit register
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_DWELL_CYCLES = 54_000_000;
    localparam int DEF_SCAN_CYCLES  = 27_000;
    localparam int DEF_BLANK_CYCLES = 16;
    localparam int DEF_DWELL_W      = clog2_min1(DEF_DWELL_CYCLES);
    localparam int DEF_SCAN_W       = clog2_min1(DEF_SCAN_CYCLES);
    localparam int DEF_BLANK_W      = clog2_min1(DEF_BLANK_CYCLES);
endpackage

// File: rtl/tm1638_display_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
//   req   : request vector
//   ptr   : search start index (< N)
//   win   : one-hot winner, zero when no request
//   valid : any request present
module rr_arbiter
    import tm1638_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                req,
    input  logic [clog2_min1(N)-1:0]    ptr,
    output logic [N-1:0]                win,
    output logic                        valid
);
    localparam int IW = clog2_min1(N);

    logic [IW-1:0] c;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        c     = ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && req[c]) begin
                win[c] = 1'b1;
                found  = 1'b1;
            end
            c = (c == IW'(N - 1)) ? '0 : c + 1'b1;
        end
    end

    assign valid = |req;
endmodule

// File: rtl/tm1638_display_scheduler.sv
// tm1638_display_scheduler: round-robin owner of the TM1638 board with dwell, blank gap and digit scan
//   req/frame_seg/frame_led : per-client request level and live frame
//   grant                   : one-hot owner
//   hgfedcba/digit/led      : registered scan outputs of the owner frame, zero when no owner
//   keys/key_evt            : key levels in, owner-only press pulses out
module tm1638_display_scheduler
    import tm1638_sched_pkg::*;
#(
    parameter int N_CLIENTS    = 4,
    parameter int W_DIGIT      = 8,
    parameter int W_LED        = 8,
    parameter int W_KEY        = 8,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int SCAN_CYCLES  = DEF_SCAN_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CLIENTS-1:0]           req,
    input  logic [N_CLIENTS*W_DIGIT*8-1:0] frame_seg,
    input  logic [N_CLIENTS*W_LED-1:0]     frame_led,
    output logic [N_CLIENTS-1:0]           grant,
    output logic [7:0]                     hgfedcba,
    output logic [W_DIGIT-1:0]             digit,
    output logic [W_LED-1:0]               led,
    input  logic [W_KEY-1:0]               keys,
    output logic [N_CLIENTS*W_KEY-1:0]     key_evt
);
    localparam int IW = clog2_min1(N_CLIENTS);
    localparam int DW = clog2_min1(DWELL_CYCLES);
    localparam int SW = clog2_min1(SCAN_CYCLES);
    localparam int BW = clog2_min1(BLANK_CYCLES);
    localparam int XW = clog2_min1(W_DIGIT);

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, own_q, own_d, win_idx;
    logic [N_CLIENTS-1:0] win, own_oh;
    logic                 win_ok, act;
    logic [DW-1:0]        dwell_q;
    logic [BW-1:0]        blank_q;
    logic [SW-1:0]        slot_q;
    logic [XW-1:0]        idx_q;
    logic [W_KEY-1:0]     key_prev;

    rr_arbiter #(.N(N_CLIENTS)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_ok)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++)
            if (win[i]) win_idx = IW'(i);
    end

    assign own_oh = N_CLIENTS'(1) << own_q;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        case (state_q)
            IDLE: if (win_ok) begin
                state_d = ACTIVE;
                own_d   = win_idx;
            end
            // owner drop preempts at once; dwell expiry only yields to a waiting client
            ACTIVE: if (!req[own_q] || (dwell_q == '0 && |(req & ~own_oh))) state_d = BLANK;
            BLANK:  if (blank_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs follow the next state so grant and the first scanned digit appear together
    assign act = (state_d == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            own_q    <= '0;
            ptr_q    <= '0;
            dwell_q  <= '0;
            blank_q  <= '0;
            slot_q   <= '0;
            idx_q    <= '0;
            key_prev <= '0;
            grant    <= '0;
            hgfedcba <= '0;
            digit    <= '0;
            led      <= '0;
            key_evt  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            key_prev <= keys;
            slot_q   <= (slot_q == SW'(SCAN_CYCLES - 1)) ? '0 : slot_q + 1'b1;
            if (slot_q == SW'(SCAN_CYCLES - 1))
                idx_q <= (idx_q == XW'(W_DIGIT - 1)) ? '0 : idx_q + 1'b1;
            if (state_q == IDLE && win_ok) begin
                dwell_q <= DW'(DWELL_CYCLES - 1);
                ptr_q   <= (win_idx == IW'(N_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
            end else if (state_q == ACTIVE && dwell_q != '0)
                dwell_q <= dwell_q - 1'b1;
            if (state_q == ACTIVE && state_d == BLANK)
                blank_q <= BW'(BLANK_CYCLES - 1);
            else if (state_q == BLANK && blank_q != '0)
                blank_q <= blank_q - 1'b1;
            grant    <= act ? N_CLIENTS'(1) << own_d : '0;
            digit    <= act ? W_DIGIT'(1) << idx_q : '0;
            hgfedcba <= act ? frame_seg[(int'(own_d) * W_DIGIT + int'(idx_q)) * 8 +: 8] : '0;
            led      <= act ? frame_led[int'(own_d) * W_LED +: W_LED] : '0;
            key_evt  <= '0;
            if (state_q == ACTIVE)
                key_evt[int'(own_q) * W_KEY +: W_KEY] <= keys & ~key_prev;
        end
    end
endmodule
